udp_pkt_framer_mc: RTL and testbench
====================================

Name: udp_pkt_framer_mc

Overview:
- Multi-channel, parametrised UDP packet framer that replaces the single-channel fixed-size packetizer.
- Round-robin arbitration over NUM_CH source FIFOs: each packet is a 5-word header, PAYLOAD_WORDS payload words read from one channel, then an XOR checksum trailer.
- Output goes to the shared 16-bit UDP TX FIFO.
- Sits between the acquisition FIFOs and the UDP/MAC stack; controlled by NIOS via begin_work and frame_length.

Parameters:
- NUM_CH, 2, number of source channels (1..4).
- PAYLOAD_WORDS, 512, payload words per packet (4..4095).
- RD_USEDW_W, 14, width of each source FIFO used-words count.
- WR_USEDW_W, 13, width of TX FIFO used-words count.
- WR_HIGH_MARK, 3000, TX FIFO used-words at or above which no new packet starts.
- HDR_MAGIC, 16'h7DA3, header word 0 before byte swap.
- SWAP_BYTES, 1, 1 = every output word byte-swapped ({w[7:0],w[15:8]}); 0 = unchanged.

Ports:
- clk  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- begin_work  in  1  arm request from NIOS; level, asynchronous to logic, 2-flop synchronised.
- packet_start  in  1  frame trigger; 2-flop synchronised, rising edge detected.
- abort  in  1  synchronous abort; return to IDLE.
- cnt_init  in  32  sequence start value, loaded into every channel at frame start.
- frame_length  in  16  packets per channel per frame.
- rd_usedw  in  NUM_CH*RD_USEDW_W  per-channel source used-words; channel c at [c*RD_USEDW_W +: RD_USEDW_W].
- data_in  in  NUM_CH*16  per-channel source q; normal mode, 1-cycle read latency.
- rden  out  NUM_CH  per-channel read enable; one-hot or zero.
- wr_usedw  in  WR_USEDW_W  TX FIFO used-words.
- data_out  out  16  TX word.
- wren  out  1  TX write enable.
- sop  out  1  high with header word 0.
- eop  out  1  high with trailer word.
- busy  out  1  registered; 0 in IDLE/ARMED, else 1.
- frame_done  out  1  one-cycle pulse when a frame completes normally.

Behaviour:
- Reset (RST high, async): all outputs 0, state IDLE, all counters 0, round-robin pointer 0.
- States:
  - IDLE: wait for synchronised begin_work → ARMED.
  - ARMED: on packet_start rising edge, load seq[c]=cnt_init and pkt[c]=0 for all c → ARB.
  - ARB: channel c is eligible when rd_usedw[c] >= PAYLOAD_WORDS, pkt[c] < frame_length, and wr_usedw < WR_HIGH_MARK.
    - Pick the first eligible channel starting at pointer+1 (mod NUM_CH) → HDR.
    - If all pkt[c] == frame_length → DONE.
    - Otherwise stay in ARB.
  - DONE: frame_done=1 for one cycle → IDLE.
- Packet word indices, with wren high contiguously for PAYLOAD_WORDS+6 cycles:
  - idx0 = HDR_MAGIC (sop=1).
  - idx1 = pkt[c][15:0].
  - idx2 = seq[c][31:16].
  - idx3 = seq[c][15:0].
  - idx4 = {14'd0, c[1:0]}.
  - idx5..idx(P+4) = payload words 0..P-1.
  - idx(P+5) = XOR of all payload words before swap (eop=1).
- Read timing: rden[c] is high during the cycles data_out holds idx3..idx(P+2), giving exactly P pulses per packet. Payload word k appears at idx 5+k, two cycles after its rden cycle.
- After the trailer: one cycle with wren=0 and data_out=0; then seq[c]+=1 (32-bit wrap), pkt[c]+=1, pointer=c → ARB.
- SWAP_BYTES is applied to all words, including the header and trailer.
- frame_length=0: ARB goes straight to DONE; no packets are emitted.
- Eligibility is sampled only in ARB. An in-flight packet is never stalled, even if the TX FIFO crosses WR_HIGH_MARK.
- packet_start edges outside ARMED are ignored. begin_work deassertion mid-frame is ignored; the frame finishes.
- abort (any state, highest priority after RST):
  - Next cycle: state IDLE, rden=0, wren=0, sop=0, eop=0.
  - A truncated packet never gets eop and no frame_done pulses.
- NUM_CH=1: the arbiter degenerates to a single channel; behaviour is otherwise identical.

Test Plan:
- NUM_CH=1, P=512, frame_length=2, cnt_init=32'h00010002, source holds 1024 words 0..1023 → 2 packets of 518 words. Packet 0 is 7DA3→A37D, 0000, 0100, 0200, 0000, swapped payload, swapped XOR of 0..511. Packet 1 has idx1=0100 and idx3=0300. One frame_done pulse follows.
- NUM_CH=2, both channels full, frame_length=3 → channel order 1,0,1,0,1,0 (pointer reset 0). Each channel's seq increments 3 times independently; 6 eop pulses.
- wr_usedw=3000 held in ARB → no sop. Drop to 2999 → sop within 2 cycles. Raising it to 3500 mid-packet → packet completes unbroken.
- abort asserted at payload word 100 → next cycle wren=0, rden=0, state IDLE, no eop and no frame_done. A subsequent begin_work plus packet_start reloads cnt_init.
- cnt_init=32'hFFFFFFFF, frame_length=2 → second packet seq words 0000/0000 (wrap). frame_length=0 → frame_done only, wren never asserted.
- SWAP_BYTES=0, PAYLOAD_WORDS=4 → 10-word packets with unswapped 7DA3 header. rden count is exactly 4 per packet.

Source files
------------

// File: rtl/udp_pkt_framer_mc.sv
// rtl/udp_pkt_framer_mc.sv - multi-channel round-robin UDP packet framer
// Header, payload and XOR trailer are emitted from registered outputs in one unbroken burst.
module udp_pkt_framer_mc #(
    parameter int          NUM_CH        = 2,
    parameter int          PAYLOAD_WORDS = 512,
    parameter int          RD_USEDW_W    = 14,
    parameter int          WR_USEDW_W    = 13,
    parameter int          WR_HIGH_MARK  = 3000,
    parameter logic [15:0] HDR_MAGIC     = 16'h7DA3,
    parameter bit          SWAP_BYTES    = 1'b1
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic                         begin_work,
    input  logic                         packet_start,
    input  logic                         abort,
    input  logic [31:0]                  cnt_init,
    input  logic [15:0]                  frame_length,
    input  logic [NUM_CH*RD_USEDW_W-1:0] rd_usedw,
    input  logic [NUM_CH*16-1:0]         data_in,
    output logic [NUM_CH-1:0]            rden,
    input  logic [WR_USEDW_W-1:0]        wr_usedw,
    output logic [15:0]                  data_out,
    output logic                         wren,
    output logic                         sop,
    output logic                         eop,
    output logic                         busy,
    output logic                         frame_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_ARB   = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [RD_USEDW_W-1:0] RD_MIN  = RD_USEDW_W'(PAYLOAD_WORDS);
    localparam logic [WR_USEDW_W-1:0] WR_MARK = WR_USEDW_W'(WR_HIGH_MARK);
    localparam logic [12:0] C_RD_FIRST = 13'd3;
    localparam logic [12:0] C_RD_LAST  = 13'(PAYLOAD_WORDS + 2);
    localparam logic [12:0] C_PL_FIRST = 13'd5;
    localparam logic [12:0] C_PL_LAST  = 13'(PAYLOAD_WORDS + 4);
    localparam logic [12:0] C_TRL      = 13'(PAYLOAD_WORDS + 5);

    logic [2:0]        state_q, state_d;
    logic              bw_s1_q, bw_s2_q;
    logic              ps_s1_q, ps_s2_q, ps_s3_q;
    logic [1:0]        ch_q, ch_d, ptr_q, ptr_d;
    logic [12:0]       cnt_q, cnt_d;
    logic [15:0]       xsum_q, xsum_d;
    logic [31:0]       seq_q [NUM_CH];
    logic [31:0]       seq_d [NUM_CH];
    logic [15:0]       pkt_q [NUM_CH];
    logic [15:0]       pkt_d [NUM_CH];
    logic [15:0]       data_out_q, data_out_d;
    logic              wren_q, wren_d, sop_q, sop_d, eop_q, eop_d;
    logic              busy_q, busy_d, frame_done_q, frame_done_d;
    logic [NUM_CH-1:0] rden_q, rden_d;

    logic [3:0]  elig;
    logic        all_done, sel_found, ps_rise, rd_win;
    logic [1:0]  sel_ch, cand;
    logic [15:0] cur_data, cur_pkt, word;
    logic [31:0] cur_seq;

    function automatic logic [15:0] swap16(input logic [15:0] w);
        return SWAP_BYTES ? {w[7:0], w[15:8]} : w;
    endfunction

    assign ps_rise = ps_s2_q & ~ps_s3_q;

    always_comb begin
        elig     = 4'b0;
        all_done = 1'b1;
        cur_data = 16'd0;
        cur_pkt  = 16'd0;
        cur_seq  = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = (rd_usedw[c*RD_USEDW_W +: RD_USEDW_W] >= RD_MIN) &&
                      (pkt_q[c] < frame_length) && (wr_usedw < WR_MARK);
            if (pkt_q[c] != frame_length) all_done = 1'b0;
            if (ch_q == 2'(c)) begin
                cur_data = data_in[c*16 +: 16];
                cur_pkt  = pkt_q[c];
                cur_seq  = seq_q[c];
            end
        end
    end

    // Search starts one past the last served channel so every channel gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = 2'((int'(ptr_q) + i) % NUM_CH);
            if (!sel_found && elig[cand]) begin
                sel_found = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    always_comb begin
        case (cnt_q)
            13'd0:   word = HDR_MAGIC;
            13'd1:   word = cur_pkt;
            13'd2:   word = cur_seq[31:16];
            13'd3:   word = cur_seq[15:0];
            13'd4:   word = {14'd0, ch_q};
            default: word = (cnt_q == C_TRL) ? xsum_q : cur_data;
        endcase
    end

    // rden is registered with data_out, so it rises while idx3 is on the bus and q lands at idx5.
    assign rd_win = (cnt_q >= C_RD_FIRST) && (cnt_q <= C_RD_LAST);

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        xsum_d       = xsum_q;
        seq_d        = seq_q;
        pkt_d        = pkt_q;
        data_out_d   = 16'd0;
        wren_d       = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        frame_done_d = 1'b0;
        rden_d       = '0;
        case (state_q)
            S_IDLE: if (bw_s2_q) state_d = S_ARMED;
            S_ARMED: begin
                if (ps_rise) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        seq_d[c] = cnt_init;
                        pkt_d[c] = 16'd0;
                    end
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (sel_found) begin
                    ch_d    = sel_ch;
                    cnt_d   = 13'd0;
                    xsum_d  = 16'd0;
                    state_d = S_SEND;
                end else if (all_done) begin
                    state_d = S_DONE;
                end
            end
            S_SEND: begin
                wren_d     = 1'b1;
                data_out_d = swap16(word);
                sop_d      = (cnt_q == 13'd0);
                eop_d      = (cnt_q == C_TRL);
                for (int c = 0; c < NUM_CH; c++) rden_d[c] = rd_win && (ch_q == 2'(c));
                if ((cnt_q >= C_PL_FIRST) && (cnt_q <= C_PL_LAST)) xsum_d = xsum_q ^ cur_data;
                if (cnt_q == C_TRL) state_d = S_GAP;
                else                cnt_d   = cnt_q + 13'd1;
            end
            S_GAP: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_q == 2'(c)) begin
                        seq_d[c] = seq_q[c] + 32'd1;
                        pkt_d[c] = pkt_q[c] + 16'd1;
                    end
                end
                ptr_d   = ch_q;
                state_d = S_ARB;
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d      = S_IDLE;
            data_out_d   = 16'd0;
            wren_d       = 1'b0;
            sop_d        = 1'b0;
            eop_d        = 1'b0;
            frame_done_d = 1'b0;
            rden_d       = '0;
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_ARMED);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            bw_s1_q      <= 1'b0;
            bw_s2_q      <= 1'b0;
            ps_s1_q      <= 1'b0;
            ps_s2_q      <= 1'b0;
            ps_s3_q      <= 1'b0;
            ch_q         <= 2'd0;
            ptr_q        <= 2'd0;
            cnt_q        <= 13'd0;
            xsum_q       <= 16'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                seq_q[c] <= 32'd0;
                pkt_q[c] <= 16'd0;
            end
            data_out_q   <= 16'd0;
            wren_q       <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rden_q       <= '0;
        end else begin
            state_q      <= state_d;
            bw_s1_q      <= begin_work;
            bw_s2_q      <= bw_s1_q;
            ps_s1_q      <= packet_start;
            ps_s2_q      <= ps_s1_q;
            ps_s3_q      <= ps_s2_q;
            ch_q         <= ch_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            xsum_q       <= xsum_d;
            seq_q        <= seq_d;
            pkt_q        <= pkt_d;
            data_out_q   <= data_out_d;
            wren_q       <= wren_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            rden_q       <= rden_d;
        end
    end

    assign data_out   = data_out_q;
    assign wren       = wren_q;
    assign sop        = sop_q;
    assign eop        = eop_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign rden       = rden_q;

endmodule

// File: tb/tb_udp_pkt_framer_mc.sv
// tb/tb_udp_pkt_framer_mc.sv - scoreboard bench for udp_pkt_framer_mc (2 channels, 16-word payload)
module tb_udp_pkt_framer_mc;

    localparam int P = 16;

    logic        clk = 1'b0;
    logic        rst, begin_work, packet_start, abort, src_clr;
    logic [31:0] cnt_init;
    logic [15:0] frame_length;
    logic [27:0] rd_usedw;
    logic [31:0] data_in;
    logic [1:0]  rden;
    logic [12:0] wr_usedw;
    logic [15:0] data_out;
    logic        wren, sop, eop, busy, frame_done;

    int n_cmp = 0, n_bad = 0, n_fd = 0, n_sop = 0, n_eop = 0;
    logic [17:0] exp_q [$];
    bit          in_pkt = 0, after_eop = 0;
    logic [15:0] src_k [2];
    logic [15:0] exp_k [2];
    logic [31:0] mseq  [2];
    logic [15:0] mpkt  [2];
    int          m_ptr = 0;

    always #5 clk = ~clk;

    udp_pkt_framer_mc #(
        .NUM_CH(2), .PAYLOAD_WORDS(P), .RD_USEDW_W(14), .WR_USEDW_W(13),
        .WR_HIGH_MARK(3000), .HDR_MAGIC(16'h7DA3), .SWAP_BYTES(1'b1)
    ) dut (
        .clk(clk), .RST(rst), .begin_work(begin_work), .packet_start(packet_start),
        .abort(abort), .cnt_init(cnt_init), .frame_length(frame_length),
        .rd_usedw(rd_usedw), .data_in(data_in), .rden(rden), .wr_usedw(wr_usedw),
        .data_out(data_out), .wren(wren), .sop(sop), .eop(eop), .busy(busy),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sw(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    // Source FIFO in normal mode: q follows rden by one clock.
    always @(posedge clk) begin
        if (src_clr) begin
            for (int c = 0; c < 2; c++) src_k[c] <= 16'd0;
            data_in <= 32'd0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (rden[c]) begin
                    data_in[c*16 +: 16] <= 16'(c * 4096) + src_k[c];
                    src_k[c] <= src_k[c] + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) n_fd++;
            if (sop) n_sop++;
            if (eop) n_eop++;
            if (rden != 2'b00) chk("rden_onehot", 32'($countones(rden)), 32'd1);
            if (after_eop) begin
                chk("gap_wren", 32'(wren), 32'd0);
                chk("gap_data", 32'(data_out), 32'd0);
                after_eop = 0;
            end else if (in_pkt) begin
                chk("contig_wren", 32'(wren), 32'd1);
            end
            if (wren) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wren", 32'(wren), 32'd0);
                end else begin
                    chk("word", 32'({sop, eop, data_out}), 32'(exp_q.pop_front()));
                    in_pkt    = !eop;
                    after_eop = eop;
                end
            end
        end
    end

    task automatic push_pkt(input int c, input logic [15:0] pk, input logic [31:0] sq);
        logic [15:0] w, x;
        x = 16'd0;
        exp_q.push_back({2'b10, sw(16'h7DA3)});
        exp_q.push_back({2'b00, sw(pk)});
        exp_q.push_back({2'b00, sw(sq[31:16])});
        exp_q.push_back({2'b00, sw(sq[15:0])});
        exp_q.push_back({2'b00, sw(16'(c))});
        for (int k = 0; k < P; k++) begin
            w = 16'(c * 4096) + exp_k[c];
            exp_k[c] = exp_k[c] + 16'd1;
            x = x ^ w;
            exp_q.push_back({2'b00, sw(w)});
        end
        exp_q.push_back({2'b01, sw(x)});
    endtask

    task automatic model_frame(input logic [31:0] init, input logic [15:0] flen, output int npk);
        bit found;
        int c;
        npk = 0;
        for (int i = 0; i < 2; i++) begin
            mseq[i] = init;
            mpkt[i] = 16'd0;
        end
        do begin
            found = 0;
            for (int i = 1; i <= 2 && !found; i++) begin
                c = (m_ptr + i) % 2;
                if (mpkt[c] < flen) begin
                    push_pkt(c, mpkt[c], mseq[c]);
                    mpkt[c] = mpkt[c] + 16'd1;
                    mseq[c] = mseq[c] + 32'd1;
                    m_ptr = c;
                    npk++;
                    found = 1;
                end
            end
        end while (found);
    endtask

    task automatic start_frame(input logic [31:0] init, input logic [15:0] flen);
        cnt_init     = init;
        frame_length = flen;
        begin_work   = 1'b1;
        repeat (4) @(negedge clk);
        packet_start = 1'b1;
        repeat (4) @(negedge clk);
        packet_start = 1'b0;
        begin_work   = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int fd0, input int eop0, input int npk);
        int i;
        for (i = 0; i < 3000 && n_fd == fd0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk({tag, "_frame_done"}, 32'(n_fd), 32'(fd0 + 1));
        chk({tag, "_eop_count"}, 32'(n_eop), 32'(eop0 + npk));
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_rden_ch0"}, 32'(src_k[0]), 32'(exp_k[0]));
        chk({tag, "_rden_ch1"}, 32'(src_k[1]), 32'(exp_k[1]));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int npk, fd0, eop0, sop0, i;
        rst = 1'b1; src_clr = 1'b1; begin_work = 1'b0; packet_start = 1'b0; abort = 1'b0;
        cnt_init = 32'd0; frame_length = 16'd0; wr_usedw = 13'd0;
        rd_usedw = {14'd1000, 14'd1000};
        exp_k[0] = 16'd0; exp_k[1] = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_sop", 32'(sop), 32'd0);
        chk("rst_eop", 32'(eop), 32'd0);
        chk("rst_rden", 32'(rden), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        rst = 1'b0; src_clr = 1'b0;
        repeat (2) @(negedge clk);

        // Round-robin over two full channels, order 1,0,1,0 from reset pointer.
        fd0 = n_fd; eop0 = n_eop;
        model_frame(32'h0001_0002, 16'd2, npk);
        start_frame(32'h0001_0002, 16'd2);
        chk("rr_busy", 32'(busy), 32'd1);
        finish_frame("rr", fd0, eop0, npk);

        // TX FIFO high-water mark gates packet start, not packets in flight.
        wr_usedw = 13'd3000;
        fd0 = n_fd; eop0 = n_eop; sop0 = n_sop;
        model_frame(32'h0000_0010, 16'd1, npk);
        start_frame(32'h0000_0010, 16'd1);
        repeat (30) @(negedge clk);
        chk("wr_mark_no_sop", 32'(n_sop), 32'(sop0));
        chk("wr_mark_busy", 32'(busy), 32'd1);
        wr_usedw = 13'd2999;
        for (i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (sop) break;
        end
        chk("wr_mark_sop_latency", 32'(i <= 2 && sop), 32'd1);
        repeat (5) @(negedge clk);
        wr_usedw = 13'd3500;
        repeat (60) @(negedge clk);
        chk("wr_mark_one_pkt", 32'(n_eop), 32'(eop0 + 1));
        wr_usedw = 13'd0;
        finish_frame("wr_mark", fd0, eop0, npk);

        // Channel 1 one word short of a payload is skipped until it reaches exactly P.
        rd_usedw = {14'(P - 1), 14'd1000};
        fd0 = n_fd; eop0 = n_eop;
        push_pkt(0, 16'd0, 32'h0000_0100);
        push_pkt(1, 16'd0, 32'h0000_0100);
        m_ptr = 1;
        start_frame(32'h0000_0100, 16'd1);
        repeat (80) @(negedge clk);
        chk("rd_min_ch0_only", 32'(n_eop), 32'(eop0 + 1));
        chk("rd_min_no_done", 32'(n_fd), 32'(fd0));
        rd_usedw = {14'(P), 14'd1000};
        finish_frame("rd_min", fd0, eop0, 2);
        rd_usedw = {14'd1000, 14'd1000};

        // Abort mid-payload: truncated packet, no eop, no frame_done.
        fd0 = n_fd; eop0 = n_eop;
        push_pkt((m_ptr + 1) % 2, 16'd0, 32'hAAAA_5555);
        start_frame(32'hAAAA_5555, 16'd1);
        for (i = 0; i < 200 && !sop; i++) @(negedge clk);
        chk("abort_sop_seen", 32'(sop), 32'd1);
        repeat (5 + 8) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        in_pkt = 0;
        after_eop = 0;
        @(negedge clk);
        chk("abort_wren", 32'(wren), 32'd0);
        chk("abort_rden", 32'(rden), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_eop", 32'(eop), 32'd0);
        abort = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_eop", 32'(n_eop), 32'(eop0));
        chk("abort_no_done", 32'(n_fd), 32'(fd0));
        chk("abort_idle_quiet", 32'(wren), 32'd0);
        src_clr = 1'b1;
        @(negedge clk);
        src_clr = 1'b0;
        exp_k[0] = 16'd0; exp_k[1] = 16'd0;

        // Fresh frame after abort reloads cnt_init.
        fd0 = n_fd; eop0 = n_eop;
        model_frame(32'h1234_5678, 16'd1, npk);
        start_frame(32'h1234_5678, 16'd1);
        finish_frame("reload", fd0, eop0, npk);

        // Sequence counter wraps to zero on the second packet of each channel.
        fd0 = n_fd; eop0 = n_eop;
        model_frame(32'hFFFF_FFFF, 16'd2, npk);
        start_frame(32'hFFFF_FFFF, 16'd2);
        finish_frame("wrap", fd0, eop0, npk);

        // Zero-length frame: only frame_done.
        fd0 = n_fd; eop0 = n_eop; sop0 = n_sop;
        start_frame(32'h0000_0000, 16'd0);
        finish_frame("flen0", fd0, eop0, 0);
        chk("flen0_no_sop", 32'(n_sop), 32'(sop0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
